mem_io_responder: RTL and testbench

- Responder end of the CPU byte bus (address, write data, write strobe in; read data out).
- Holds the 128 KB program/data RAM and the memory-mapped I/O page at mem_a[17:16]==2'b11.
- I/O page contains:
  - a UART TX byte FIFO,
  - a UART RX byte FIFO,
  - a free-running cycle counter,
  - a program-stop latch.
- Sits between the CPU core and the UART/host link.

---
 rtl/mem_io_responder_pkg.sv | 45 ++++
 rtl/mem_io_responder_if.sv | 35 +++
 rtl/mem_io_responder_byte_fifo.sv | 74 +++++++
 rtl/mem_io_responder.sv | 150 +++++++++++++++
 tb/tb_mem_io_responder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the CPU byte-bus responder.
// Holds the I/O page address map, the byte width and the default sizing
// parameters, plus the decoder that maps an 18-bit bus address to an I/O
// register.
package mem_io_responder_pkg;

  localparam int BYTE_W = 8;

  localparam int DEF_RAM_ADDR_W      = 17;
  localparam int DEF_FIFO_DEPTH_LOG2 = 4;
  localparam int DEF_FULL_MARGIN     = 2;

  localparam logic [1:0]  IO_PAGE       = 2'b11;
  localparam logic [17:0] IO_UART_ADDR  = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR   = 18'h30004;
  localparam logic [17:0] IO_SNAP1_ADDR = 18'h30005;
  localparam logic [17:0] IO_SNAP2_ADDR = 18'h30006;
  localparam logic [17:0] IO_SNAP3_ADDR = 18'h30007;

  typedef logic [BYTE_W-1:0] byte_t;

  // Register selected inside the I/O page
  typedef enum logic [2:0] {
    IO_NONE,
    IO_UART,
    IO_SNAP0,
    IO_SNAP1,
    IO_SNAP2,
    IO_SNAP3
  } io_reg_e;

  function automatic io_reg_e decode_io(input logic [17:0] addr);
    io_reg_e r;
    case (addr)
      IO_UART_ADDR:  r = IO_UART;
      IO_CLK_ADDR:   r = IO_SNAP0;
      IO_SNAP1_ADDR: r = IO_SNAP1;
      IO_SNAP2_ADDR: r = IO_SNAP2;
      IO_SNAP3_ADDR: r = IO_SNAP3;
      default:       r = IO_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Bus bundle between the CPU core / UART link and the responder.
// Signals:
//   mem_a, mem_wdata, mem_wr   CPU address, write byte, write strobe
//   mem_rdata                  registered read byte (1-cycle latency)
//   io_buffer_full             TX FIFO near-full flag
//   tx_data/tx_valid/tx_ready  byte stream to the UART transmitter
//   rx_data/rx_valid/rx_ready  byte stream from the UART receiver
//   program_done               sticky stop flag
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  logic [31:0] mem_a;
  byte_t       mem_wdata;
  logic        mem_wr;
  byte_t       mem_rdata;
  logic        io_buffer_full;
  byte_t       tx_data;
  logic        tx_valid;
  logic        tx_ready;
  byte_t       rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_done;

  modport responder (
    input  mem_a, mem_wdata, mem_wr, tx_ready, rx_data, rx_valid,
    output mem_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, program_done
  );

  modport master (
    output mem_a, mem_wdata, mem_wr, tx_ready, rx_data, rx_valid,
    input  mem_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, program_done
  );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   push_i, data_i   write request and byte
//   pop_i            read request (head advances on the edge)
//   head_o           current head byte (valid while !empty_o)
//   empty_o, full_o  status
//   count_o          current occupancy
//   count_next_o     occupancy after this edge
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
// when a pop frees the slot in the same cycle.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                push_i,
  input  byte_t               data_i,
  input  logic                pop_i,
  output byte_t               head_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [DEPTH_LOG2:0] count_o,
  output logic [DEPTH_LOG2:0] count_next_o
);

  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  byte_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage carries data only and is never reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte bus: 128 KB RAM plus the I/O page at
// address bits [17:16] == 2'b11 (UART TX/RX FIFOs, cycle counter snapshot,
// program-stop latch).
// Ports:
//   clk_in    system clock
//   rst_in_n  asynchronous active-low reset
//   bus       responder side of mem_io_responder_if (CPU bus + UART link)
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W      = DEF_RAM_ADDR_W,
  parameter int FIFO_DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2,
  parameter int FULL_MARGIN     = DEF_FULL_MARGIN
) (
  input logic                   clk_in,
  input logic                   rst_in_n,
  mem_io_responder_if.responder bus
);

  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  // Address decode
  logic [17:0]           addr18;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  io_sel;
  io_reg_e               io_reg;

  assign addr18   = bus.mem_a[17:0];
  assign ram_addr = bus.mem_a[RAM_ADDR_W-1:0];
  assign io_sel   = (addr18[17:16] == IO_PAGE);
  assign io_reg   = io_sel ? decode_io(addr18) : IO_NONE;

  // Registered state
  logic [31:0] cycle_q, snap_q;
  logic        done_q;
  logic        ibf_q, ibf_d;
  logic        sel_io_q;
  byte_t       io_rd_q, io_rd_d;
  byte_t       ram_rd_q;

  // FIFO hookup
  logic          tx_push, tx_pop, tx_empty, tx_full;
  byte_t         tx_push_data, tx_head;
  logic [CW-1:0] tx_count, tx_count_next;
  logic          rx_push, rx_pop, rx_empty, rx_full;
  byte_t         rx_head;
  logic [CW-1:0] rx_count, rx_count_next;
  logic          snap_latch, done_set, ram_we;
  logic [CW-1:0] tx_free_next;

  always_comb begin
    ram_we       = bus.mem_wr && !io_sel;
    done_set     = bus.mem_wr && (io_reg == IO_SNAP0);
    // The stop write pushes a 0x00 marker; ordinary zero bytes are ignored
    tx_push      = bus.mem_wr && (((io_reg == IO_UART) && (bus.mem_wdata != '0)) ||
                                  (io_reg == IO_SNAP0));
    tx_push_data = (io_reg == IO_SNAP0) ? '0 : bus.mem_wdata;
    tx_pop       = !tx_empty && bus.tx_ready;
    rx_push      = bus.rx_valid && !rx_full;
    rx_pop       = !bus.mem_wr && (io_reg == IO_UART);
    snap_latch   = !bus.mem_wr && (io_reg == IO_SNAP0);
  end

  // I/O read mux; the RAM byte is taken from its own register
  always_comb begin
    io_rd_d = '0;
    unique case (io_reg)
      IO_UART:  io_rd_d = rx_empty ? '0 : rx_head;
      IO_SNAP0: io_rd_d = cycle_q[7:0];
      IO_SNAP1: io_rd_d = snap_q[15:8];
      IO_SNAP2: io_rd_d = snap_q[23:16];
      IO_SNAP3: io_rd_d = snap_q[31:24];
      default:  io_rd_d = '0;
    endcase
  end

  // Flag leads true full by FULL_MARGIN entries
  always_comb begin
    tx_free_next = CW'(DEPTH) - tx_count_next;
    ibf_d        = (tx_free_next <= CW'(FULL_MARGIN));
  end

  byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk_i        (clk_in),
    .rst_n_i      (rst_in_n),
    .push_i       (tx_push),
    .data_i       (tx_push_data),
    .pop_i        (tx_pop),
    .head_o       (tx_head),
    .empty_o      (tx_empty),
    .full_o       (tx_full),
    .count_o      (tx_count),
    .count_next_o (tx_count_next)
  );

  byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk_i        (clk_in),
    .rst_n_i      (rst_in_n),
    .push_i       (rx_push),
    .data_i       (bus.rx_data),
    .pop_i        (rx_pop),
    .head_o       (rx_head),
    .empty_o      (rx_empty),
    .full_o       (rx_full),
    .count_o      (rx_count),
    .count_next_o (rx_count_next)
  );

  // Control and I/O read registers
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      cycle_q  <= '0;
      snap_q   <= '0;
      done_q   <= 1'b0;
      ibf_q    <= 1'b0;
      sel_io_q <= 1'b1;
      io_rd_q  <= '0;
    end else begin
      if (!done_q)    cycle_q <= cycle_q + 32'd1;
      if (snap_latch) snap_q  <= cycle_q;
      if (done_set)   done_q  <= 1'b1;
      ibf_q <= ibf_d;
      // Read data holds across write cycles
      if (!bus.mem_wr) begin
        sel_io_q <= io_sel;
        io_rd_q  <= io_rd_d;
      end
    end
  end

  // Inferred single-port RAM; contents survive reset
  byte_t ram_q [1 << RAM_ADDR_W];

  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_addr] <= bus.mem_wdata;
    if (!bus.mem_wr) ram_rd_q <= ram_q[ram_addr];
  end

  assign bus.mem_rdata      = sel_io_q ? io_rd_q : ram_rd_q;
  assign bus.io_buffer_full = ibf_q;
  assign bus.tx_data        = tx_head;
  assign bus.tx_valid       = !tx_empty;
  assign bus.rx_ready       = !rx_full;
  assign bus.program_done   = done_q;

  logic unused_bits;
  assign unused_bits = ^{bus.mem_a[31:18], tx_full, tx_count, rx_count, rx_count_next};

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM access, TX/RX FIFOs, near-full
// flag, cycle-counter snapshot, program stop and asynchronous reset.
module tb_mem_io_responder;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mem_io_responder_if bus ();

  mem_io_responder dut (
    .clk_in   (clk),
    .rst_in_n (rst_n),
    .bus      (bus.responder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.mem_a     = 32'h0;
    bus.mem_wdata = 8'h00;
    bus.mem_wr    = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.mem_a     = a;
    bus.mem_wdata = d;
    bus.mem_wr    = 1'b1;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a);
    bus.mem_a  = a;
    bus.mem_wr = 1'b0;
    step();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle();
    step();
    step();
    chk("reset_rdata", bus.mem_rdata, 8'h00);
    chk("reset_ibf", 8'(bus.io_buffer_full), 8'h00);
    chk("reset_tx_valid", 8'(bus.tx_valid), 8'h00);
    chk("reset_rx_ready", 8'(bus.rx_ready), 8'h01);
    chk("reset_done", 8'(bus.program_done), 8'h00);
    rst_n = 1'b1;

    // RAM write / read, hold on write, read-after-write
    wr(32'h00010, 8'hA5);
    rd(32'h00010);
    chk("ram_rd_10", bus.mem_rdata, 8'hA5);
    wr(32'h00020, 8'h77);
    chk("rdata_hold_on_wr", bus.mem_rdata, 8'hA5);
    rd(32'h00020);
    chk("ram_raw_20", bus.mem_rdata, 8'h77);
    wr(32'h1FFFF, 8'h5C);
    pulse_reset();
    rd(32'h1FFFF);
    chk("ram_survives_reset", bus.mem_rdata, 8'h5C);
    idle();

    // TX: zero byte ignored, FWFT drain
    wr(32'h30000, 8'h41);
    wr(32'h30000, 8'h00);
    wr(32'h30000, 8'h42);
    chk("tx_valid_pending", 8'(bus.tx_valid), 8'h01);
    chk("tx_head0", bus.tx_data, 8'h41);
    bus.tx_ready = 1'b1;
    step();
    chk("tx_head1", bus.tx_data, 8'h42);
    chk("tx_valid1", 8'(bus.tx_valid), 8'h01);
    step();
    chk("tx_drained", 8'(bus.tx_valid), 8'h00);
    bus.tx_ready = 1'b0;

    // TX fill: near-full flag, drop when full, ordered drain
    for (int i = 0; i < 16; i++) begin
      wr(32'h30000, 8'(16 + i));
      chk($sformatf("ibf_after_push%0d", i + 1), 8'(bus.io_buffer_full),
          8'((16 - (i + 1)) <= 2));
    end
    wr(32'h30000, 8'hEE);
    chk("ibf_full_drop", 8'(bus.io_buffer_full), 8'h01);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tx_fill_valid%0d", i), 8'(bus.tx_valid), 8'h01);
      chk($sformatf("tx_fill_data%0d", i), bus.tx_data, 8'(16 + i));
      step();
    end
    chk("tx_fill_empty", 8'(bus.tx_valid), 8'h00);
    chk("ibf_cleared", 8'(bus.io_buffer_full), 8'h00);
    bus.tx_ready = 1'b0;

    // RX: push two, read three
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h31;
    step();
    bus.rx_data  = 8'h32;
    step();
    bus.rx_valid = 1'b0;
    chk("rx_ready_partial", 8'(bus.rx_ready), 8'h01);
    rd(32'h30000);
    chk("rx_rd0", bus.mem_rdata, 8'h31);
    rd(32'h30000);
    chk("rx_rd1", bus.mem_rdata, 8'h32);
    rd(32'h30000);
    chk("rx_rd_empty", bus.mem_rdata, 8'h00);
    idle();

    // RX full: back-pressure, overflow byte not taken
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.rx_data = 8'(80 + i);
      step();
    end
    chk("rx_ready_full", 8'(bus.rx_ready), 8'h00);
    bus.rx_data = 8'hFF;
    step();
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd(32'h30000);
      chk($sformatf("rx_full_rd%0d", i), bus.mem_rdata, 8'(80 + i));
      if (i == 0) chk("rx_ready_after_pop", 8'(bus.rx_ready), 8'h01);
    end
    rd(32'h30000);
    chk("rx_overflow_dropped", bus.mem_rdata, 8'h00);
    idle();

    // Cycle counter snapshot: 100 edges after release
    pulse_reset();
    repeat (100) step();
    rd(32'h30004);
    chk("snap_b0", bus.mem_rdata, 8'h64);
    rd(32'h30005);
    chk("snap_b1", bus.mem_rdata, 8'h00);
    rd(32'h30006);
    chk("snap_b2", bus.mem_rdata, 8'h00);
    rd(32'h30007);
    chk("snap_b3", bus.mem_rdata, 8'h00);
    rd(32'h30004);
    chk("snap_relatch", bus.mem_rdata, 8'h68);
    rd(32'h30003);
    chk("io_unmapped", bus.mem_rdata, 8'h00);
    idle();

    // Program stop: marker byte, sticky flag, frozen counter
    pulse_reset();
    repeat (5) step();
    wr(32'h30004, 8'h99);
    chk("done_set", 8'(bus.program_done), 8'h01);
    chk("stop_tx_valid", 8'(bus.tx_valid), 8'h01);
    chk("stop_tx_byte", bus.tx_data, 8'h00);
    repeat (3) step();
    rd(32'h30004);
    chk("counter_frozen", bus.mem_rdata, 8'h06);
    idle();
    bus.tx_ready = 1'b1;
    step();
    chk("stop_byte_sent", 8'(bus.tx_valid), 8'h00);
    bus.tx_ready = 1'b0;
    chk("done_sticky", 8'(bus.program_done), 8'h01);

    // Asynchronous reset mid-transfer
    wr(32'h30000, 8'h61);
    rd(32'h00010);
    chk("pre_reset_rdata", bus.mem_rdata, 8'hA5);
    chk("pre_reset_tx_valid", 8'(bus.tx_valid), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rdata", bus.mem_rdata, 8'h00);
    chk("async_tx_valid", 8'(bus.tx_valid), 8'h00);
    chk("async_done", 8'(bus.program_done), 8'h00);
    chk("async_rx_ready", 8'(bus.rx_ready), 8'h01);
    chk("async_ibf", 8'(bus.io_buffer_full), 8'h00);
    idle();
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
